// File: rtl/s27_bist_ctrl.sv
// Logic-BIST controller for the s27 core: LFSR stimulus, serial MISR compaction, pass/fail flag.
// Optional macro S27_BIST_SIG_OBS_EN adds the sig[7:0] port exposing live MISR contents.
module s27_bist_ctrl #(
    parameter int unsigned N_PATTERNS = 15,
    parameter logic [3:0]  SEED       = 4'h1,
    parameter int unsigned FLUSH_CYC  = 3,
    parameter logic [3:0]  FLUSH_VEC  = 4'h0,
    parameter int unsigned RESP_LAT   = 0,
    parameter logic [7:0]  MISR_POLY  = 8'h1D,
    parameter logic [7:0]  GOLDEN_SIG = 8'h00
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       start,
    output logic [3:0] stim,
    input  logic       resp,
    output logic       busy,
    output logic       done,
    output logic       pass
`ifdef S27_BIST_SIG_OBS_EN
    ,
    output logic [7:0] sig
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYC - 1);
    localparam logic [15:0] RUN_LAST   = 16'(N_PATTERNS - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(RESP_LAT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  lfsr;
    logic [3:0]  lfsr_next;
    logic [7:0]  misr;
    logic [7:0]  misr_next;
    logic        in_run;
    logic        cap_en;

    assign in_run    = (state == RUN);
    assign lfsr_next = {lfsr[2:0], lfsr[3] ^ lfsr[2]};

    // Capture strobe follows each RUN cycle by RESP_LAT cycles.
    generate
        if (RESP_LAT == 0) begin : g_cap_now
            assign cap_en = in_run;
        end else if (RESP_LAT == 1) begin : g_cap_one
            logic cap_q;
            always_ff @(posedge CK) begin
                if (RST) cap_q <= 1'b0;
                else     cap_q <= in_run;
            end
            assign cap_en = cap_q;
        end else begin : g_cap_sr
            logic [RESP_LAT-1:0] cap_sr;
            always_ff @(posedge CK) begin
                if (RST) cap_sr <= '0;
                else     cap_sr <= {cap_sr[RESP_LAT-2:0], in_run};
            end
            assign cap_en = cap_sr[RESP_LAT-1];
        end
    endgenerate

    always_comb begin
        misr_next = misr;
        if (cap_en)
            misr_next = {misr[6:0], 1'b0} ^ (misr[7] ? MISR_POLY : 8'h00) ^ {7'b0, resp};
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state <= IDLE;
            stim  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
            misr  <= '0;
            lfsr  <= SEED;
            cnt   <= '0;
        end else begin
            misr <= misr_next;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= FLUSH;
                        stim  <= FLUSH_VEC;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                        misr  <= '0;
                        lfsr  <= SEED;
                        cnt   <= '0;
                    end
                end
                FLUSH: begin
                    if (cnt == FLUSH_LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                        stim  <= lfsr;
                        lfsr  <= lfsr_next;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RUN: begin
                    if (cnt == RUN_LAST) begin
                        cnt  <= '0;
                        stim <= '0;
                        // With zero latency the last capture lands on this same edge.
                        if (RESP_LAT == 0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (misr_next == GOLDEN_SIG);
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        cnt  <= cnt + 16'd1;
                        stim <= lfsr;
                        lfsr <= lfsr_next;
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state <= DONE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (misr_next == GOLDEN_SIG);
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef S27_BIST_SIG_OBS_EN
    assign sig = misr;
`endif

endmodule
